// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing a Register16bit bank between requesters; replays the winning command for its burst length.
// Latency: Req sampled at a grant edge drives RegE in the next cycle; one IDLE bubble between commands.
// Backpressure: a requester holds Req until its Ack; dropping Req mid-burst abandons the command in that same cycle.
module reg_access_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NUM_REG = 4,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [2*NUM_REQ-1:0]     ReqFunSel,
    input  logic [SEL_W*NUM_REQ-1:0] ReqSel,
    input  logic [16*NUM_REQ-1:0]    ReqData,
    input  logic [CNT_W*NUM_REQ-1:0] ReqCount,
    output logic [NUM_REQ-1:0]       Grant,
    output logic [NUM_REQ-1:0]       Ack,
    output logic [NUM_REG-1:0]       RegE,
    output logic [1:0]               FunSel,
    output logic [15:0]              I,
    output logic                     Busy
);

    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t             state_q, state_d;
    logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [1:0]         funsel_q, funsel_d;
    logic [15:0]        data_q, data_d;
    logic [CNT_W-1:0]   rem_q, rem_d;

    logic               win_vld;
    logic [OWN_W-1:0]   win_idx;
    logic               req_own;
    logic [1:0]         win_fs;
    logic [CNT_W-1:0]   win_cnt;

    // Pick the first active requester at or above rr_ptr, wrapping; scanning down lets the nearest one win.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (Req[idx]) begin
                win_vld = 1'b1;
                win_idx = OWN_W'(idx);
            end
        end
    end

    // Owner's request level; only this requester can steer outputs during EXEC.
    always_comb begin
        req_own = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (int'(owner_q) == r) req_own = Req[r];
        end
    end

    // Next-state: capture the winner's command at grant, count the burst down, drop out on abandon.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        sel_d    = sel_q;
        funsel_d = funsel_q;
        data_d   = data_q;
        rem_d    = rem_q;
        win_fs   = ReqFunSel[int'(win_idx)*2 +: 2];
        win_cnt  = ReqCount[int'(win_idx)*CNT_W +: CNT_W];
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d  = EXEC;
                    owner_d  = win_idx;
                    rr_ptr_d = OWN_W'((int'(win_idx) + 1) % NUM_REQ);
                    sel_d    = ReqSel[int'(win_idx)*SEL_W +: SEL_W];
                    funsel_d = win_fs;
                    data_d   = ReqData[int'(win_idx)*16 +: 16];
                    // Load and clear are idempotent, so they never repeat.
                    rem_d    = (win_fs[1] || (win_cnt == '0)) ? CNT_W'(1) : win_cnt;
                end
            end
            EXEC: begin
                if (!req_own) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched command registers; reset aborts any burst without an Ack.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            sel_q    <= '0;
            funsel_q <= 2'b00;
            data_q   <= 16'h0000;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            sel_q    <= sel_d;
            funsel_q <= funsel_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
        end
    end

    // Bank-facing outputs depend only on state and the owner's Req; out-of-range sel leaves RegE idle.
    always_comb begin
        Busy   = (state_q == EXEC);
        FunSel = funsel_q;
        I      = data_q;
        Grant  = '0;
        Ack    = '0;
        RegE   = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (Busy && int'(owner_q) == r) begin
                Grant[r] = 1'b1;
                Ack[r]   = req_own && (rem_q == CNT_W'(1));
            end
        end
        for (int g = 0; g < NUM_REG; g++) begin
            RegE[g] = Busy && req_own && (int'(sel_q) == g);
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a behavioural Register16bit bank attached.
// Second instance with NUM_REG=3 covers the out-of-range select no-op.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_reg_access_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [3:0]  Req;
    logic [7:0]  ReqFunSel;
    logic [7:0]  ReqSel;
    logic [63:0] ReqData;
    logic [15:0] ReqCount;
    logic [3:0]  Grant, Ack, RegE;
    logic [1:0]  FunSel;
    logic [15:0] I;
    logic        Busy;
    logic [3:0]  Grant3, Ack3;
    logic [2:0]  RegE3;
    logic [1:0]  FunSel3;
    logic [15:0] I3;
    logic        Busy3;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] regm [4] = '{16'd5, 16'd5, 16'd5, 16'd5};

    always #5 Clock = ~Clock;

    reg_access_arbiter u_dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .ReqFunSel(ReqFunSel), .ReqSel(ReqSel),
        .ReqData(ReqData), .ReqCount(ReqCount), .Grant(Grant), .Ack(Ack), .RegE(RegE),
        .FunSel(FunSel), .I(I), .Busy(Busy)
    );

    reg_access_arbiter #(.NUM_REG(3)) u_dut3 (
        .Clock(Clock), .Reset(Reset), .Req(Req), .ReqFunSel(ReqFunSel), .ReqSel(ReqSel),
        .ReqData(ReqData), .ReqCount(ReqCount), .Grant(Grant3), .Ack(Ack3), .RegE(RegE3),
        .FunSel(FunSel3), .I(I3), .Busy(Busy3)
    );

    // Register16bit model: 00 decrement, 01 increment, 10 load, 11 clear.
    always @(posedge Clock) begin
        for (int r = 0; r < 4; r++) begin
            if (RegE[r]) begin
                case (FunSel)
                    2'b00: regm[r] <= regm[r] - 16'd1;
                    2'b01: regm[r] <= regm[r] + 16'd1;
                    2'b10: regm[r] <= I;
                    default: regm[r] <= 16'h0000;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic set_cmd(input int r, input logic [1:0] fs, input logic [1:0] sel,
                           input logic [15:0] d, input logic [3:0] cnt);
        ReqFunSel[2*r +: 2]  = fs;
        ReqSel[2*r +: 2]     = sel;
        ReqData[16*r +: 16]  = d;
        ReqCount[4*r +: 4]   = cnt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        Reset = 1'b0; Req = '0; ReqFunSel = '0; ReqSel = '0; ReqData = '0; ReqCount = '0;

        // Reset state
        @(negedge Clock);
        Req = 4'b1111;
        @(negedge Clock);
        chk("rst_grant", Grant, 4'b0000);
        chk("rst_rege", RegE, 4'b0000);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_ack", Ack, 4'b0000);
        chk("rst_funsel", FunSel, 2'b00);
        chk("rst_i", I, 16'h0000);
        Req = '0;
        Reset = 1'b1;
        @(negedge Clock);

        // Single increment burst of 3 on reg 2 (5 -> 8)
        set_cmd(1, 2'b01, 2'd2, 16'h0000, 4'd3);
        Req = 4'b0010;
        step;
        chk("t1_c1_grant", Grant, 4'b0010);
        chk("t1_c1_rege", RegE, 4'b0100);
        chk("t1_c1_funsel", FunSel, 2'b01);
        chk("t1_c1_ack", Ack, 4'b0000);
        set_cmd(1, 2'b11, 2'd0, 16'hFFFF, 4'd1);
        step;
        chk("t1_c2_rege", RegE, 4'b0100);
        chk("t1_c2_funsel", FunSel, 2'b01);
        chk("t1_c2_ack", Ack, 4'b0000);
        step;
        chk("t1_c3_ack", Ack, 4'b0010);
        chk("t1_c3_rege", RegE, 4'b0100);
        step;
        chk("t1_done_busy", Busy, 1'b0);
        chk("t1_done_grant", Grant, 4'b0000);
        Req = '0;
        chk("t1_reg2", regm[2], 16'h0008);

        // Load ignores count
        set_cmd(0, 2'b10, 2'd0, 16'hBEEF, 4'd7);
        Req = 4'b0001;
        step;
        chk("t2_grant", Grant, 4'b0001);
        chk("t2_i", I, 16'hBEEF);
        chk("t2_funsel", FunSel, 2'b10);
        chk("t2_ack", Ack, 4'b0001);
        chk("t2_rege", RegE, 4'b0001);
        step;
        chk("t2_busy", Busy, 1'b0);
        Req = '0;
        chk("t2_reg0", regm[0], 16'hBEEF);

        // Round-robin from a fresh pointer
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        for (int r = 0; r < 4; r++) set_cmd(r, 2'b01, 2'd3, 16'h0000, 4'd1);
        Req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step;
            chk($sformatf("rr%0d_grant", k), Grant, exp_g[k]);
            chk($sformatf("rr%0d_ack", k), Ack, exp_g[k]);
            step;
            chk($sformatf("rr%0d_bubble", k), Busy, 1'b0);
        end
        Req = '0;
        chk("rr_reg3", regm[3], 16'd10);

        // Abandon a decrement burst in its 3rd cycle
        set_cmd(2, 2'b00, 2'd1, 16'h0000, 4'd5);
        Req = 4'b0100;
        step;
        chk("t4_c1_rege", RegE, 4'b0010);
        step;
        step;
        Req = '0;
        #1;
        chk("t4_c3_rege", RegE, 4'b0000);
        chk("t4_c3_ack", Ack, 4'b0000);
        chk("t4_c3_grant", Grant, 4'b0100);
        step;
        chk("t4_idle", Busy, 1'b0);
        chk("t4_reg1", regm[1], 16'd3);

        // Async reset mid-burst
        set_cmd(3, 2'b01, 2'd3, 16'h0000, 4'd5);
        Req = 4'b1000;
        step;
        chk("t5_busy", Busy, 1'b1);
        chk("t5_grant", Grant, 4'b1000);
        #2;
        Reset = 1'b0;
        #1;
        chk("t5_rst_grant", Grant, 4'b0000);
        chk("t5_rst_rege", RegE, 4'b0000);
        chk("t5_rst_busy", Busy, 1'b0);
        chk("t5_rst_ack", Ack, 4'b0000);
        @(negedge Clock);
        set_cmd(0, 2'b01, 2'd0, 16'h0000, 4'd1);
        Req = 4'b1001;
        Reset = 1'b1;
        step;
        chk("t5_first_grant", Grant, 4'b0001);
        step;
        Req = '0;

        // count=0 behaves as a single cycle
        set_cmd(1, 2'b01, 2'd2, 16'h0000, 4'd0);
        Req = 4'b0010;
        step;
        chk("t6_ack", Ack, 4'b0010);
        step;
        chk("t6_busy", Busy, 1'b0);
        Req = '0;
        chk("t6_reg2", regm[2], 16'd9);

        // Out-of-range select on a 3-register bank
        set_cmd(2, 2'b01, 2'd3, 16'h1234, 4'd2);
        Req = 4'b0100;
        step;
        chk("t7_c1_rege3", RegE3, 3'b000);
        chk("t7_c1_grant3", Grant3, 4'b0100);
        chk("t7_c1_ack3", Ack3, 4'b0000);
        chk("t7_c1_rege4", RegE, 4'b1000);
        step;
        chk("t7_c2_ack3", Ack3, 4'b0100);
        chk("t7_c2_rege3", RegE3, 3'b000);
        chk("t7_c2_i3", I3, 16'h1234);
        chk("t7_c2_funsel3", FunSel3, 2'b01);
        step;
        chk("t7_busy3", Busy3, 1'b0);
        Req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Shares a bank of NUM_REG Register16bit instances between NUM_REQ requesters.
- Each requester issues one command: target register, FunSel, load data and repeat count.
- The block arbitrates round-robin, latches the winning command and drives the bank's per-register enables, the common FunSel and the common data input for the required number of cycles.
- It sits between the control/sequencing logic and the register bank in the datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_REG, 4, number of registers in the bank.
- SEL_W, 2, width of register select; must satisfy 2^SEL_W >= NUM_REG.
- CNT_W, 4, width of burst repeat count.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  NUM_REQ  per-requester request; held high until Ack or abandon.
- ReqFunSel  in  2*NUM_REQ  FunSel per requester, slice i = [2i+1:2i].
- ReqSel  in  SEL_W*NUM_REQ  target register index per requester.
- ReqData  in  16*NUM_REQ  load data per requester.
- ReqCount  in  CNT_W*NUM_REQ  repeat count per requester; 0 is treated as 1.
- Grant  out  NUM_REQ  one-hot; high for every EXEC cycle of the owner.
- Ack  out  NUM_REQ  one-hot; one-cycle pulse on the owner's final EXEC cycle.
- RegE  out  NUM_REG  one-hot enable to the bank; all zero outside EXEC.
- FunSel  out  2  common FunSel to the bank.
- I  out  16  common data input to the bank.
- Busy  out  1  high while in EXEC.

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE, rr_ptr=0, latched command cleared (sel=0, funsel=2'b00, data=0, remaining=0).
  - Grant, Ack, RegE, Busy all 0; FunSel=2'b00; I=16'h0000.
  - Reset asserted during EXEC aborts immediately; no Ack is issued.
- FSM states: IDLE, EXEC.
- IDLE:
  - With no Req, stay in IDLE.
  - Otherwise the winner is the first requester with Req high, searching from rr_ptr upward with wrap-around.
  - At the clock edge: latch the winner's sel/funsel/data; set owner=winner; set rr_ptr=(winner+1) mod NUM_REQ; go to EXEC.
  - remaining = 1 when funsel is 2'b10 (load) or 2'b11 (clear), or when count=0; otherwise remaining = count.
- EXEC, combinational outputs:
  - Busy=1; Grant[owner]=1.
  - RegE[sel]=1 when Req[owner]=1; FunSel and I driven from the latched command.
  - Ack[owner]=1 when remaining=1 and Req[owner]=1.
- EXEC, sequential:
  - If Req[owner]=0, the command is abandoned: RegE=0 and Ack=0 in that same cycle, and the FSM goes to IDLE.
  - Else if remaining=1, go to IDLE.
  - Else remaining -= 1 and stay in EXEC.
- Timing:
  - Latency: Req sampled high at edge k gives RegE high in cycle k+1.
  - EXEC lasts exactly remaining cycles.
  - At least one IDLE cycle separates consecutive commands (arbitration bubble).
- Input capture: inputs other than Req are sampled only at the grant edge. Later changes to a requester's command fields do not affect a command in flight.
- sel >= NUM_REG: RegE is all zero for the whole burst, but Grant and Ack still behave normally. This is the defined no-op.
- Requesters other than the owner are ignored during EXEC. They keep waiting, and no request is lost.
- Counting: count is unsigned; the maximum burst is 2^CNT_W-1 cycles. Wrap-around of register contents is handled by the register, not by this block.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 other commands.
- Outputs are glitch-free with respect to the clock; they depend only on state and on Req[owner].

Test Plan:
- Reset then single command: Req[1] with sel=2, funsel=2'b01, count=3. Required: Grant[1] and RegE=4'b0100, FunSel=01 for exactly 3 cycles starting 1 cycle after Req; Ack[1] on the 3rd cycle; an attached register starting at 16'h0005 reads 16'h0008.
- Load ignores count: Req[0] with funsel=10, data=16'hBEEF, count=7. Required: exactly 1 EXEC cycle with I=16'hBEEF and Ack[0]; the register reads 16'hBEEF.
- Round-robin: Req=4'b1111 held continuously, each command count=1. Required grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Abandon mid-burst: Req[2] with decrement, count=5; drop Req[2] in the 3rd EXEC cycle. Required: RegE=0 in that cycle, no Ack, IDLE next cycle; register decremented by 2 only.
- Async reset mid-burst: Reset low during EXEC between clock edges. Required: Grant, RegE and Busy go to 0 immediately; after release, first grant goes to requester 0.
- Edge cases: count=0 must give a 1-cycle EXEC; sel=3 with NUM_REG=3 must give RegE all zero for the burst while Ack is still issued.
